// File: rtl/stepper_pkg.sv
// Shared types and register map for the stepper motion sequencer.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    HIGH,
    LOW
  } state_t;

  localparam logic [1:0] ADDR_POS    = 2'd0;
  localparam logic [1:0] ADDR_HALF   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_REMAIN = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_ZERO    = 2;
  localparam int CTRL_CLR_OVF = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 8;
  localparam int STAT_CNT_LSB = 16;

  // A programmed half period of zero still yields one-cycle phases.
  function automatic logic [31:0] eff_half(input logic [31:0] hp);
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/stepper_motion_sequencer_if.sv
// Host register bus (Avalon-MM style) between the HPS bridge and the sequencer.
interface stepper_motion_sequencer_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/stepper_cmd_fifo.sv
// Move queue: 32-bit synchronous FIFO with flush; head is a registered read of the RAM.
module stepper_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [31:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [31:0]   head_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = head_reg;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // The head only needs to be valid one cycle after the pointer settles, which
  // the sequencer guarantees by spending a cycle in IDLE before every LOAD.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
    head_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/stepper_motion_sequencer.sv
// Queued relative-move controller: buffers signed moves and plays them out as step/dir trains.
module stepper_motion_sequencer
  import stepper_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 4,
  parameter int          DIR_SETUP_CYC = 25,
  parameter logic [31:0] HALF_PER_RST  = 32'd2
) (
  input  logic                         clk,
  input  logic                         reset,
  stepper_motion_sequencer_if.slave    bus,
  output logic                         step,
  output logic                         dir,
  output logic                         busy
);
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP_CYC - 1);

  state_t        state_reg, state_next;
  logic [31:0]   cnt_reg;
  logic [31:0]   remaining_reg;
  logic [31:0]   position_reg;
  logic [31:0]   half_period_reg;
  logic [31:0]   readdata_reg;
  logic [31:0]   status;
  logic          dir_reg;
  logic          enable_reg;
  logic          overflow_reg;

  logic          wr_pos, wr_half, wr_ctrl;
  logic          abort, zero_pos, clr_ovf;
  logic          enter_setup, enter_high, enter_low;
  logic [31:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign wr_pos   = bus.write && (bus.address == ADDR_POS);
  assign wr_half  = bus.write && (bus.address == ADDR_HALF);
  assign wr_ctrl  = bus.write && (bus.address == ADDR_CTRL);
  assign abort    = wr_ctrl && bus.writedata[CTRL_ABORT];
  assign zero_pos = wr_ctrl && bus.writedata[CTRL_ZERO];
  assign clr_ovf  = wr_ctrl && bus.writedata[CTRL_CLR_OVF];

  stepper_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_pos && !abort),
    .push_data (bus.writedata),
    .pop       (state_reg == LOAD),
    .flush     (abort),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!fifo_empty && enable_reg && !abort) state_next = LOAD;
      LOAD:  state_next = (abort || fifo_head == 32'd0) ? IDLE : SETUP;
      SETUP: if (abort) state_next = IDLE;
             else if (cnt_reg == 32'd0) state_next = HIGH;
      HIGH:  if (cnt_reg == 32'd0) state_next = LOW;
      // Holding here with cnt at zero is the paused state.
      LOW:   if (cnt_reg == 32'd0) begin
               if (remaining_reg == 32'd0 || abort) state_next = IDLE;
               else if (enable_reg)                 state_next = HIGH;
             end
      default: state_next = IDLE;
    endcase
  end

  assign enter_setup = (state_next == SETUP) && (state_reg != SETUP);
  assign enter_high  = (state_next == HIGH)  && (state_reg != HIGH);
  assign enter_low   = (state_next == LOW)   && (state_reg != LOW);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg         <= '0;
      remaining_reg   <= '0;
      position_reg    <= '0;
      half_period_reg <= HALF_PER_RST;
      dir_reg         <= 1'b1;
      enable_reg      <= 1'b1;
      overflow_reg    <= 1'b0;
      readdata_reg    <= '0;
    end else begin
      if (wr_half) half_period_reg <= bus.writedata;
      if (wr_ctrl) enable_reg <= bus.writedata[CTRL_ENABLE];

      if (wr_pos && !abort && fifo_full) overflow_reg <= 1'b1;
      else if (clr_ovf)                  overflow_reg <= 1'b0;

      if (enter_setup)                   cnt_reg <= SETUP_LOAD;
      else if (enter_high || enter_low)  cnt_reg <= eff_half(half_period_reg) - 32'd1;
      else if (cnt_reg != 32'd0)         cnt_reg <= cnt_reg - 32'd1;

      if (state_reg == LOAD && state_next == SETUP) begin
        dir_reg       <= !fifo_head[31];
        remaining_reg <= fifo_head[31] ? (32'd0 - fifo_head) : fifo_head;
      end
      // Saturating so an abort-zeroed count is not wrapped by the pending LOW.
      if (enter_low && remaining_reg != 32'd0) remaining_reg <= remaining_reg - 32'd1;
      if (abort) remaining_reg <= '0;

      if (enter_high) position_reg <= dir_reg ? position_reg + 32'd1 : position_reg - 32'd1;
      if (zero_pos)   position_reg <= '0;

      readdata_reg <= '0;
      if (bus.read) begin
        case (bus.address)
          ADDR_POS:  readdata_reg <= position_reg;
          ADDR_HALF: readdata_reg <= half_period_reg;
          ADDR_CTRL: readdata_reg <= status;
          default:   readdata_reg <= remaining_reg;
        endcase
      end
    end
  end

  always_comb begin
    status                           = '0;
    status[STAT_BUSY]                = busy;
    status[STAT_FULL]                = fifo_full;
    status[STAT_EMPTY]               = fifo_empty;
    status[STAT_OVF]                 = overflow_reg;
    status[STAT_CNT_LSB +: 8]        = 8'(fifo_count);
  end

  assign step         = (state_reg == HIGH);
  assign dir          = dir_reg;
  assign busy         = (state_reg != IDLE) || !fifo_empty;
  assign bus.readdata = readdata_reg;

endmodule

// File: tb/tb_stepper_motion_sequencer.sv
// Randomized self-checking bench: pulse-train monitor plus a move-list position model.
module tb_stepper_motion_sequencer;
  import stepper_pkg::*;

  localparam int SETUP_CYC = 25;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic step, dir, busy;
  always #5 clk = ~clk;

  stepper_motion_sequencer_if bus_if ();

  stepper_motion_sequencer #(
    .FIFO_DEPTH    (4),
    .DIR_SETUP_CYC (SETUP_CYC),
    .HALF_PER_RST  (32'd2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .step  (step),
    .dir   (dir),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Pulse monitor: records dir and high/low widths of every step pulse.
  bit   prev_step = 1'b0;
  bit   prev_dir  = 1'b1;
  int   dir_stable = 0, hi_len = 0, lo_len = 0, rise_cnt = 0;
  bit   got_dir[$];
  int   got_hi[$];
  int   got_lo[$];

  always @(negedge clk) begin
    if (dir == prev_dir) dir_stable++;
    else dir_stable = 0;
    if (step && !prev_step) begin
      check("dir_setup_hold", 32'(dir_stable >= SETUP_CYC), 32'd1);
      rise_cnt++;
      got_dir.push_back(dir);
      got_lo.push_back(lo_len);
      hi_len = 1;
    end else if (step) begin
      hi_len++;
    end else if (prev_step) begin
      got_hi.push_back(hi_len);
      lo_len = 1;
    end else begin
      lo_len++;
    end
    prev_step = step;
    prev_dir  = dir;
  end

  task automatic clear_mon();
    rise_cnt = 0;
    got_dir.delete();
    got_hi.delete();
    got_lo.delete();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address   = a;
    bus_if.writedata = d;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.address = a;
    bus_if.read    = 1'b1;
    @(negedge clk);
    bus_if.read    = 1'b0;
    d = bus_if.readdata;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_rises(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (rise_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rise_wait"}, 32'(rise_cnt >= target), 32'd1);
  endtask

  // Reference model: absolute position is the modular sum of all executed moves.
  logic [31:0] exp_pos = '0;
  int          moves[$];

  task automatic run_batch(input string tag, input logic [31:0] hp);
    int          total, bad, hpe, n;
    bit          exp_dir[$];
    logic [31:0] rd;
    hpe = (hp == 32'd0) ? 1 : int'(hp);
    bus_write(ADDR_HALF, hp);
    clear_mon();
    total = 0;
    foreach (moves[i]) begin
      n = (moves[i] < 0) ? -moves[i] : moves[i];
      for (int k = 0; k < n; k++) exp_dir.push_back(moves[i] >= 0);
      total += n;
    end
    foreach (moves[i]) begin
      bus_write(ADDR_POS, 32'(moves[i]));
      exp_pos = exp_pos + 32'(moves[i]);
      $display("%s: push move %0d half_period %0d", tag, moves[i], hp);
    end
    wait_idle(tag, 20000);
    check({tag, "_pulses"}, 32'(rise_cnt), 32'(total));
    bad = 0;
    foreach (got_dir[i]) if (i >= exp_dir.size() || got_dir[i] != exp_dir[i]) bad++;
    check({tag, "_dir_errs"}, 32'(bad), 32'd0);
    bad = 0;
    foreach (got_hi[i]) if (got_hi[i] != hpe) bad++;
    check({tag, "_high_width_errs"}, 32'(bad), 32'd0);
    bus_read(ADDR_POS, rd);
    check({tag, "_pos"}, rd, exp_pos);
  endtask

  initial begin
    logic [31:0] rd;
    int          r, nm;
    logic [31:0] hp;

    bus_if.address   = '0;
    bus_if.writedata = '0;
    bus_if.write     = 1'b0;
    bus_if.read      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_step", 32'(step), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_readdata", bus_if.readdata, 32'd0);
    reset = 1'b1;
    bus_read(ADDR_POS, rd);    check("rst_pos", rd, 32'd0);
    bus_read(ADDR_HALF, rd);   check("rst_half", rd, 32'd2);
    bus_read(ADDR_CTRL, rd);   check("rst_status", rd, 32'h0000_0004);
    bus_read(ADDR_REMAIN, rd); check("rst_remaining", rd, 32'd0);

    // Single +3 move: also check the low widths between pulses
    moves = '{3};
    run_batch("t1", 32'd2);
    if (got_lo.size() >= 3) begin
      check("t1_low1", 32'(got_lo[1]), 32'd2);
      check("t1_low2", 32'(got_lo[2]), 32'd2);
    end else begin
      check("t1_low_count", 32'(got_lo.size()), 32'd3);
    end

    // Direction reversal across back-to-back moves
    moves = '{-5, 2};
    run_batch("t2", 32'd2);

    // Overflow: hold execution so the queue fills
    bus_write(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) bus_write(ADDR_POS, 32'd1);
    bus_read(ADDR_CTRL, rd); check("t3_status_full", rd, 32'h0004_0103);
    bus_write(ADDR_CTRL, 32'h8);
    bus_read(ADDR_CTRL, rd); check("t3_status_clr", rd, 32'h0004_0003);
    bus_write(ADDR_CTRL, 32'h2);
    bus_read(ADDR_CTRL, rd); check("t3_status_flushed", rd, 32'h0000_0004);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus_read(ADDR_POS, rd);  check("t3_pos", rd, exp_pos);

    // Abort during the 10th pulse of a long move
    bus_write(ADDR_HALF, 32'd4);
    clear_mon();
    bus_write(ADDR_POS, 32'd100);
    wait_rises("t4", 10, 2000);
    bus_write(ADDR_CTRL, 32'h3);
    wait_idle("t4", 100);
    exp_pos = exp_pos + 32'd10;
    check("t4_pulses", 32'(rise_cnt), 32'd10);
    check("t4_last_high", 32'(got_hi.size() == 10 ? got_hi[9] : 0), 32'd4);
    bus_read(ADDR_POS, rd);    check("t4_pos", rd, exp_pos);
    bus_read(ADDR_CTRL, rd);   check("t4_status", rd, 32'h0000_0004);
    bus_read(ADDR_REMAIN, rd); check("t4_remaining", rd, 32'd0);

    // Pause and resume
    bus_write(ADDR_HALF, 32'd2);
    clear_mon();
    bus_write(ADDR_POS, 32'd10);
    wait_rises("t5", 3, 500);
    bus_write(ADDR_CTRL, 32'h0);
    repeat (40) @(negedge clk);
    r = rise_cnt;
    repeat (40) @(negedge clk);
    check("t5_paused_pulses", 32'(rise_cnt), 32'(r));
    check("t5_paused_step", 32'(step), 32'd0);
    bus_read(ADDR_REMAIN, rd); check("t5_remaining", rd, 32'(10 - r));
    bus_read(ADDR_POS, rd);    check("t5_paused_pos", rd, exp_pos + 32'(r));
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle("t5", 2000);
    exp_pos = exp_pos + 32'd10;
    check("t5_pulses", 32'(rise_cnt), 32'd10);
    bus_read(ADDR_POS, rd);    check("t5_pos", rd, exp_pos);

    // Re-zero, wrap through zero, zero-length move
    bus_write(ADDR_CTRL, 32'h5);
    exp_pos = '0;
    bus_read(ADDR_POS, rd);    check("t6_zeroed", rd, 32'd0);
    moves = '{-1};
    run_batch("t6a", 32'd1);
    moves = '{2};
    run_batch("t6b", 32'd1);
    clear_mon();
    bus_write(ADDR_POS, 32'd0);
    wait_idle("t6_zero_move", 4);
    check("t6_zero_pulses", 32'(rise_cnt), 32'd0);
    bus_read(ADDR_POS, rd);    check("t6_zero_pos", rd, exp_pos);

    // Most-negative move: magnitude 2^31, paused then aborted
    clear_mon();
    bus_write(ADDR_POS, 32'h8000_0000);
    wait_rises("t7", 5, 500);
    bus_write(ADDR_CTRL, 32'h0);
    repeat (30) @(negedge clk);
    r = rise_cnt;
    check("t7_dir", 32'(dir), 32'd0);
    bus_read(ADDR_REMAIN, rd); check("t7_remaining", rd, 32'h8000_0000 - 32'(r));
    bus_write(ADDR_CTRL, 32'h3);
    wait_idle("t7", 100);
    exp_pos = exp_pos - 32'(r);
    check("t7_pulses", 32'(rise_cnt), 32'(r));
    bus_read(ADDR_POS, rd);    check("t7_pos", rd, exp_pos);

    // Randomized batches
    for (int round = 0; round < 8; round++) begin
      hp = 32'($urandom_range(0, 3));
      nm = $urandom_range(1, 4);
      moves.delete();
      for (int i = 0; i < nm; i++) moves.push_back(int'($urandom_range(0, 12)) - 6);
      run_batch($sformatf("rnd%0d", round), hp);
      bus_read(ADDR_HALF, rd);   check("rnd_half_readback", rd, hp);
      bus_read(ADDR_CTRL, rd);   check("rnd_status", rd, 32'h0000_0004);
    end

    // Reset mid-move
    bus_write(ADDR_HALF, 32'd3);
    clear_mon();
    bus_write(ADDR_POS, 32'hFFFF_FFEC);
    wait_rises("t8", 2, 500);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t8_step", 32'(step), 32'd0);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_dir", 32'(dir), 32'd1);
    reset = 1'b1;
    bus_read(ADDR_POS, rd);    check("t8_pos", rd, 32'd0);
    bus_read(ADDR_HALF, rd);   check("t8_half", rd, 32'd2);
    bus_read(ADDR_CTRL, rd);   check("t8_status", rd, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
